// File: rtl/dot_product_core.sv
// Dot-product compute core: C[c_addr] = sum A[a_base+k*a_stride] * B[b_base+k*b_stride], via req/gnt dmem port.
// Optional macro DOTCORE_SATURATE_EN: saturate the result to the signed DATA_W range instead of wrapping.
module dot_product_core #(
  parameter int unsigned CORE_ID = 0,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] a_stride,
  input  logic [ADDR_W-1:0] b_stride,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [LEN_W-1:0]  k_len,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              read_MD,
  output logic              write_MD,
  output logic [ADDR_W-1:0] ar_out,
  input  logic [DATA_W-1:0] dmem_in,
  output logic [DATA_W-1:0] dmem_out,
  output logic              busy,
  output logic              end_i,
  output logic [15:0]       core_id_out
);

  localparam int unsigned ACC_W = 2 * DATA_W + LEN_W;
  localparam int unsigned CNT_W = 3;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_WT_A, S_RD_B, S_WT_B, S_MAC, S_WR, S_DONE
  } state_t;

  state_t                   r_state,    w_state_nxt;
  logic [ADDR_W-1:0]        r_a_ptr,    w_a_ptr_nxt;
  logic [ADDR_W-1:0]        r_b_ptr,    w_b_ptr_nxt;
  logic [ADDR_W-1:0]        r_a_stride, w_a_stride_nxt;
  logic [ADDR_W-1:0]        r_b_stride, w_b_stride_nxt;
  logic [ADDR_W-1:0]        r_c_addr,   w_c_addr_nxt;
  logic [LEN_W-1:0]         r_k_len,    w_k_len_nxt;
  logic [LEN_W-1:0]         r_k,        w_k_nxt;
  logic signed [ACC_W-1:0]  r_acc,      w_acc_nxt;
  logic [DATA_W-1:0]        r_opa,      w_opa_nxt;
  logic [DATA_W-1:0]        r_opb,      w_opb_nxt;
  logic [CNT_W-1:0]         r_wcnt,     w_wcnt_nxt;
  logic                     r_mem_req,  w_mem_req_nxt;
  logic                     r_read,     w_read_nxt;
  logic                     r_write,    w_write_nxt;
  logic [ADDR_W-1:0]        r_ar,       w_ar_nxt;
  logic [DATA_W-1:0]        r_dout,     w_dout_nxt;
  logic                     r_busy,     w_busy_nxt;
  logic                     r_end,      w_end_nxt;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_mac_acc;
  logic [LEN_W:0]             w_k_inc;
  logic                       w_last;
  logic                       w_wait_done;
  logic [DATA_W-1:0]          w_result;

  assign w_prod      = $signed(r_opa) * $signed(r_opb);
  assign w_mac_acc   = r_acc + ACC_W'(w_prod);
  assign w_k_inc     = (LEN_W+1)'(r_k) + (LEN_W+1)'(1);
  assign w_last      = (w_k_inc >= (LEN_W+1)'(r_k_len));
  assign w_wait_done = (r_wcnt == CNT_W'(MEM_LAT - 1));

  // Final result from the accumulator value being written in the last MAC cycle
  always_comb begin
`ifdef DOTCORE_SATURATE_EN
    if (w_mac_acc > SAT_MAX)      w_result = SAT_MAX[DATA_W-1:0];
    else if (w_mac_acc < SAT_MIN) w_result = SAT_MIN[DATA_W-1:0];
    else                          w_result = w_mac_acc[DATA_W-1:0];
`else
    w_result = w_mac_acc[DATA_W-1:0];
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_a_ptr_nxt    = r_a_ptr;
    w_b_ptr_nxt    = r_b_ptr;
    w_a_stride_nxt = r_a_stride;
    w_b_stride_nxt = r_b_stride;
    w_c_addr_nxt   = r_c_addr;
    w_k_len_nxt    = r_k_len;
    w_k_nxt        = r_k;
    w_acc_nxt      = r_acc;
    w_opa_nxt      = r_opa;
    w_opb_nxt      = r_opb;
    w_wcnt_nxt     = r_wcnt;
    w_ar_nxt       = r_ar;
    w_dout_nxt     = r_dout;
    w_busy_nxt     = r_busy;
    w_end_nxt      = r_end;
    unique case (r_state)
      S_IDLE: begin
        if (START) begin
          w_a_ptr_nxt    = a_base;
          w_b_ptr_nxt    = b_base;
          w_a_stride_nxt = a_stride;
          w_b_stride_nxt = b_stride;
          w_c_addr_nxt   = c_addr;
          w_k_len_nxt    = k_len;
          w_k_nxt        = '0;
          w_acc_nxt      = '0;
          w_busy_nxt     = 1'b1;
          w_end_nxt      = 1'b0;
          if (k_len == '0) begin
            w_state_nxt = S_WR;
            w_ar_nxt    = c_addr;
            w_dout_nxt  = '0;
          end else begin
            w_state_nxt = S_RD_A;
            w_ar_nxt    = a_base;
          end
        end
      end
      S_RD_A: begin
        if (mem_gnt) begin
          w_state_nxt = S_WT_A;
          w_wcnt_nxt  = '0;
        end
      end
      S_WT_A: begin
        if (w_wait_done) begin
          w_opa_nxt   = dmem_in;
          w_state_nxt = S_RD_B;
          w_ar_nxt    = r_b_ptr;
        end else begin
          w_wcnt_nxt  = r_wcnt + CNT_W'(1);
        end
      end
      S_RD_B: begin
        if (mem_gnt) begin
          w_state_nxt = S_WT_B;
          w_wcnt_nxt  = '0;
        end
      end
      S_WT_B: begin
        if (w_wait_done) begin
          w_opb_nxt   = dmem_in;
          w_state_nxt = S_MAC;
        end else begin
          w_wcnt_nxt  = r_wcnt + CNT_W'(1);
        end
      end
      S_MAC: begin
        w_acc_nxt   = w_mac_acc;
        w_a_ptr_nxt = r_a_ptr + r_a_stride;
        w_b_ptr_nxt = r_b_ptr + r_b_stride;
        w_k_nxt     = LEN_W'(w_k_inc);
        if (w_last) begin
          w_state_nxt = S_WR;
          w_ar_nxt    = r_c_addr;
          w_dout_nxt  = w_result;
        end else begin
          w_state_nxt = S_RD_A;
          w_ar_nxt    = r_a_ptr + r_a_stride;
        end
      end
      S_WR: begin
        if (mem_gnt) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_end_nxt   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Strobes follow the state being entered so they are registered with it
    w_read_nxt    = (w_state_nxt == S_RD_A) || (w_state_nxt == S_RD_B);
    w_write_nxt   = (w_state_nxt == S_WR);
    w_mem_req_nxt = w_read_nxt || w_write_nxt;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_a_ptr    <= '0;
      r_b_ptr    <= '0;
      r_a_stride <= '0;
      r_b_stride <= '0;
      r_c_addr   <= '0;
      r_k_len    <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_wcnt     <= '0;
      r_mem_req  <= 1'b0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_ar       <= '0;
      r_dout     <= '0;
      r_busy     <= 1'b0;
      r_end      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a_ptr    <= w_a_ptr_nxt;
      r_b_ptr    <= w_b_ptr_nxt;
      r_a_stride <= w_a_stride_nxt;
      r_b_stride <= w_b_stride_nxt;
      r_c_addr   <= w_c_addr_nxt;
      r_k_len    <= w_k_len_nxt;
      r_k        <= w_k_nxt;
      r_acc      <= w_acc_nxt;
      r_opa      <= w_opa_nxt;
      r_opb      <= w_opb_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_read     <= w_read_nxt;
      r_write    <= w_write_nxt;
      r_ar       <= w_ar_nxt;
      r_dout     <= w_dout_nxt;
      r_busy     <= w_busy_nxt;
      r_end      <= w_end_nxt;
    end
  end

  assign mem_req     = r_mem_req;
  assign read_MD     = r_read;
  assign write_MD    = r_write;
  assign ar_out      = r_ar;
  assign dmem_out    = r_dout;
  assign busy        = r_busy;
  assign end_i       = r_end;
  assign core_id_out = 16'(CORE_ID);

endmodule

// File: tb/tb_dot_product_core.sv
// Self-checking bench for dot_product_core: directed jobs plus randomized jobs against an arithmetic reference model.
module tb_dot_product_core;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 16;
  localparam int unsigned LW  = 8;
  localparam int unsigned LAT = 1;
  localparam int unsigned CID = 5;

  logic          clk = 1'b0;
  logic          RESET, START, mem_gnt;
  logic [AW-1:0] a_base, b_base, a_stride, b_stride, c_addr, ar_out;
  logic [LW-1:0] k_len;
  logic          mem_req, read_MD, write_MD, busy, end_i;
  logic [DW-1:0] dmem_in, dmem_out;
  logic [15:0]   core_id_out;

  always #5 clk = ~clk;

  dot_product_core #(.CORE_ID(CID), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .RESET(RESET), .START(START),
    .a_base(a_base), .b_base(b_base), .a_stride(a_stride), .b_stride(b_stride),
    .c_addr(c_addr), .k_len(k_len),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .read_MD(read_MD), .write_MD(write_MD),
    .ar_out(ar_out), .dmem_in(dmem_in), .dmem_out(dmem_out),
    .busy(busy), .end_i(end_i), .core_id_out(core_id_out)
  );

  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] pipe [0:LAT];
  int            checks = 0, errors = 0;
  int            rd_cnt = 0, wr_cnt = 0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  bit            stall = 1'b0, mon_en = 1'b0;
  int            wcnt = 0;
  logic          p_req = 1'b0, p_gnt = 1'b1, p_rd = 1'b0, p_wr = 1'b0;
  logic [AW-1:0] p_ar = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Grant generator: optionally withholds grant for 5 cycles on every request
  assign mem_gnt = !stall || (wcnt >= 5);
  always @(posedge clk) begin
    if (!mem_req || mem_gnt) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  // Memory model: read data appears LAT cycles after the grant cycle, garbage otherwise
  assign dmem_in = pipe[LAT];
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = (mem_req && mem_gnt && read_MD) ? mem[ar_out] : DW'($urandom);
    if (mem_req && mem_gnt && read_MD) rd_cnt++;
    if (mem_req && mem_gnt && write_MD) begin
      wr_cnt++;
      wr_addr = ar_out;
      wr_data = dmem_out;
    end
    if (mon_en) begin
      chk("rw_exclusive", 32'(read_MD && write_MD), 0);
      chk("strobe_no_req", 32'(!mem_req && (read_MD || write_MD)), 0);
      if (p_req && !p_gnt) begin
        chk("hold_ar", 32'(ar_out), 32'(p_ar));
        chk("hold_rd", 32'(read_MD), 32'(p_rd));
        chk("hold_wr", 32'(write_MD), 32'(p_wr));
      end
    end
    p_req = mem_req; p_gnt = mem_gnt; p_ar = ar_out; p_rd = read_MD; p_wr = write_MD;
  end

  function automatic logic [DW-1:0] model(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                                          input logic [AW-1:0] as, input logic [AW-1:0] bs, input int kl);
    longint        sum = 0;
    logic [AW-1:0] aa, ba;
    for (int k = 0; k < kl; k++) begin
      aa  = AW'(ab + AW'(k) * as);
      ba  = AW'(bb + AW'(k) * bs);
      sum += longint'($signed(mem[aa])) * longint'($signed(mem[ba]));
    end
`ifdef DOTCORE_SATURATE_EN
    if (sum > 32767)       return 16'h7FFF;
    else if (sum < -32768) return 16'h8000;
`endif
    return sum[DW-1:0];
  endfunction

  task automatic drive_cfg(input logic [AW-1:0] ab, input logic [AW-1:0] bb, input logic [AW-1:0] as,
                           input logic [AW-1:0] bs, input logic [AW-1:0] ca, input int kl);
    a_base = ab; b_base = bb; a_stride = as; b_stride = bs; c_addr = ca; k_len = LW'(kl);
  endtask

  task automatic run_job(input string tag, input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                         input logic [AW-1:0] as, input logic [AW-1:0] bs, input logic [AW-1:0] ca,
                         input int kl, input bit lat_chk, output logic [DW-1:0] got);
    logic [DW-1:0] exp;
    int            rd0, wr0, lat;
    exp = model(ab, bb, as, bs, kl);
    rd0 = rd_cnt; wr0 = wr_cnt;
    drive_cfg(ab, bb, as, bs, ca, kl);
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    lat = 1;
    chk({tag, "_busy_on"}, 32'(busy), 1);
    chk({tag, "_end_clr"}, 32'(end_i), 0);
    while (!end_i && lat < 4000) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_end"}, 32'(end_i), 1);
    if (lat_chk) chk({tag, "_latency"}, 32'(lat), 32'(kl * (2 * (1 + LAT) + 1) + 2));
    chk({tag, "_busy_off"}, 32'(busy), 0);
    chk({tag, "_nwrites"}, 32'(wr_cnt - wr0), 1);
    chk({tag, "_nreads"}, 32'(rd_cnt - rd0), 32'(2 * kl));
    chk({tag, "_waddr"}, 32'(wr_addr), 32'(ca));
    chk({tag, "_result"}, 32'(wr_data), 32'(exp));
    got = wr_data;
    @(negedge clk);
    chk({tag, "_end_hold"}, 32'(end_i), 1);
  endtask

  task automatic load_t1();
    mem[16'h10] = 16'd1; mem[16'h11] = 16'd2; mem[16'h12] = 16'd3;
    mem[16'h20] = 16'd4; mem[16'h24] = 16'd5; mem[16'h28] = 16'd6;
  endtask

  initial begin
    logic [DW-1:0] r;
    int            wr0;
    RESET = 1'b1; START = 1'b0;
    drive_cfg('0, '0, '0, '0, '0, 0);
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_read", 32'(read_MD), 0);
    chk("rst_write", 32'(write_MD), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_end", 32'(end_i), 0);
    chk("rst_ar", 32'(ar_out), 0);
    chk("rst_dout", 32'(dmem_out), 0);
    chk("core_id", 32'(core_id_out), CID);
    RESET = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    load_t1();
    run_job("t1", 16'h10, 16'h20, 16'd1, 16'd4, 16'h40, 3, 1'b1, r);
    chk("t1_const", 32'(r), 32);

    run_job("klen0", 16'h10, 16'h20, 16'd1, 16'd4, 16'h50, 0, 1'b1, r);
    chk("klen0_const", 32'(r), 0);

    mem[16'h80] = 16'hFFFD; mem[16'h90] = 16'd7;
    run_job("signed", 16'h80, 16'h90, 16'd1, 16'd1, 16'h44, 1, 1'b1, r);
    chk("signed_const", 32'(r), 32'h0000FFEB);

    stall = 1'b1;
    run_job("stall", 16'h10, 16'h20, 16'd1, 16'd4, 16'h40, 3, 1'b0, r);
    chk("stall_const", 32'(r), 32);
    stall = 1'b0;

    mem[16'h100] = 16'h7FFF; mem[16'h101] = 16'h7FFF;
    mem[16'h200] = 16'h7FFF; mem[16'h201] = 16'h7FFF;
    run_job("ovf", 16'h100, 16'h200, 16'd1, 16'd1, 16'h48, 2, 1'b1, r);
`ifdef DOTCORE_SATURATE_EN
    chk("ovf_const", 32'(r), 32'h7FFF);
`else
    chk("ovf_const", 32'(r), 32'h0002);
`endif

    // Abort a running job with RESET; no result write may follow
    wr0 = wr_cnt;
    drive_cfg(16'h10, 16'h20, 16'd1, 16'd4, 16'h40, 3);
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    repeat (5) @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    chk("abort_mem_req", 32'(mem_req), 0);
    chk("abort_read", 32'(read_MD), 0);
    chk("abort_write", 32'(write_MD), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_end", 32'(end_i), 0);
    chk("abort_ar", 32'(ar_out), 0);
    chk("abort_dout", 32'(dmem_out), 0);
    repeat (40) @(negedge clk);
    chk("abort_no_write", 32'(wr_cnt - wr0), 0);
    run_job("rerun", 16'h10, 16'h20, 16'd1, 16'd4, 16'h40, 3, 1'b1, r);
    chk("rerun_const", 32'(r), 32);

    // Address wrap-around across the top of memory
    for (int i = 0; i < 4; i++) mem[16'(16'hFFFE + i)] = DW'($urandom);
    for (int i = 0; i < 4; i++) mem[16'(16'h300 + 2 * i)] = DW'($urandom);
    run_job("wrap", 16'hFFFE, 16'h300, 16'd1, 16'd2, 16'h60, 4, 1'b1, r);

    // Randomized jobs, random stalls
    for (int n = 0; n < 12; n++) begin
      logic [AW-1:0] ab, bb, as, bs, ca;
      int            kl;
      kl = $urandom_range(0, 6);
      ab = AW'($urandom); bb = AW'($urandom);
      as = AW'($urandom_range(0, 3)); bs = AW'($urandom_range(0, 5));
      ca = AW'($urandom);
      for (int k = 0; k < kl; k++) begin
        mem[AW'(ab + AW'(k) * as)] = DW'($urandom);
        mem[AW'(bb + AW'(k) * bs)] = DW'($urandom);
      end
      stall = bit'($urandom_range(0, 1));
      run_job($sformatf("rnd%0d", n), ab, bb, as, bs, ca, kl, !stall, r);
    end
    stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
